// File: rtl/axis_frame_sender_if.sv
// ---------------------------------------------------------------------------
// axis_frame_sender_if
// Bundles every non-clock/reset signal of axis_frame_sender. It holds the
// command handshake, the start handshake, the memory read port, the AXI-Stream
// master bus and a debug view of the FSM state.
//   master modport : the frame sender's view (drives cmd_*, ex_start, mem_adr,
//                    mem_rd, m_*, dbg_state)
//   slave modport  : the environment's view (drives cmd_go, ex_startAck,
//                    mem_data, m_ready)
// Stream handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both 1. Once m_valid is high, it stays high, and m_data and
// m_last stay stable, until that beat occurs. m_valid never depends
// combinationally on m_ready.
// ---------------------------------------------------------------------------
interface axis_frame_sender_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADRWIDTH  = 10
);
    logic                 cmd_go;
    logic                 cmd_busy;
    logic                 cmd_done;
    logic                 cmd_err;
    logic                 ex_start;
    logic                 ex_startAck;
    logic [ADRWIDTH-1:0]  mem_adr;
    logic                 mem_rd;
    logic [DATAWIDTH-1:0] mem_data;
    logic [DATAWIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic [2:0]           dbg_state;

    modport master (
        input  cmd_go, ex_startAck, mem_data, m_ready,
        output cmd_busy, cmd_done, cmd_err, ex_start,
               mem_adr, mem_rd, m_data, m_valid, m_last, dbg_state
    );

    modport slave (
        output cmd_go, ex_startAck, mem_data, m_ready,
        input  cmd_busy, cmd_done, cmd_err, ex_start,
               mem_adr, mem_rd, m_data, m_valid, m_last, dbg_state
    );
endinterface

// File: rtl/axis_frame_sender.sv
// ---------------------------------------------------------------------------
// axis_frame_sender
// Transmitter side of the buffered AXI-Stream image path. On cmd_go it
// performs the ex_start/ex_startAck handshake with the downstream buffer. It
// then reads NUMOFDATA words from a synchronous-read memory (data one cycle
// after mem_rd) and sends them as one AXI-Stream frame, with m_last on the
// final word.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - axis_frame_sender_if.master (command, start handshake, memory
//          read port, stream master, dbg_state = current FSM state)
// ---------------------------------------------------------------------------
module axis_frame_sender #(
    parameter int DATAWIDTH     = 32,
    parameter int NUMOFDATA     = 784,
    parameter int START_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_frame_sender_if.master   bus
);
    localparam int ADRWIDTH = $clog2(NUMOFDATA);
    localparam int CTRWIDTH = ADRWIDTH + 1;
    localparam int TOWIDTH  = $clog2(START_TIMEOUT);

    localparam logic [CTRWIDTH-1:0] C_NUM       = CTRWIDTH'(NUMOFDATA);
    localparam logic [CTRWIDTH-1:0] C_LAST_BEAT = CTRWIDTH'(NUMOFDATA - 1);
    localparam logic [TOWIDTH-1:0]  C_TO_LAST   = TOWIDTH'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ACKWAIT = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_err;
    logic [CTRWIDTH-1:0]    r_rd_ctr;
    logic [CTRWIDTH-1:0]    r_beat_ctr;
    logic [TOWIDTH-1:0]     r_to;
    logic                   r_inflight;
    logic                   r_out_v;
    logic [DATAWIDTH-1:0]   r_out_data;
    logic                   r_skid_v;
    logic [DATAWIDTH-1:0]   r_skid_data;

    logic                   w_beat;
    logic                   w_last;
    logic                   w_rd;
    logic [1:0]             w_pending;

    assign w_beat = r_out_v & bus.m_ready;
    assign w_last = r_out_v & (r_beat_ctr == C_LAST_BEAT);

    // Words held or on their way after this edge. A beat leaving this cycle
    // frees its slot now, so a read can be issued every cycle while the
    // stream drains. This makes mem_rd (not m_valid) depend on m_ready.
    assign w_pending = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_inflight) - 2'(w_beat);

    assign w_rd = (r_state == S_STREAM) && (r_rd_ctr < C_NUM) && (w_pending < 2'd2);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.cmd_go) w_next = S_REQ;
            S_REQ: begin
                if (bus.ex_startAck)          w_next = S_ACKWAIT;
                else if (r_to == C_TO_LAST)   w_next = S_IDLE;
            end
            // Wait until downstream has left its start state.
            S_ACKWAIT: if (!bus.ex_startAck) w_next = S_STREAM;
            S_STREAM:  if (w_beat && w_last) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_rd_ctr   <= '0;
            r_beat_ctr <= '0;
            r_to       <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd;
            if (r_state == S_IDLE && bus.cmd_go) begin
                r_err      <= 1'b0;
                r_rd_ctr   <= '0;
                r_beat_ctr <= '0;
                r_to       <= '0;
            end
            if (r_state == S_REQ && !bus.ex_startAck) begin
                if (r_to == C_TO_LAST) r_err <= 1'b1;
                else                   r_to  <= r_to + TOWIDTH'(1);
            end
            if (w_rd)   r_rd_ctr   <= r_rd_ctr + CTRWIDTH'(1);
            if (w_beat) r_beat_ctr <= r_beat_ctr + CTRWIDTH'(1);
        end
    end

    // Output register plus one skid entry. Returning read data goes to the
    // output register when it is empty or being drained. Otherwise it goes to
    // the skid. Because the skid always holds the older word, it moves to the
    // output first, and address order is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v     <= 1'b0;
            r_out_data  <= '0;
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
        end else if (!r_out_v || w_beat) begin
            if (r_skid_v) begin
                r_out_data <= r_skid_data;
                r_out_v    <= 1'b1;
                if (r_inflight) r_skid_data <= bus.mem_data;
                else            r_skid_v    <= 1'b0;
            end else if (r_inflight) begin
                r_out_data <= bus.mem_data;
                r_out_v    <= 1'b1;
            end else begin
                r_out_v    <= 1'b0;
            end
        end else if (r_inflight) begin
            r_skid_data <= bus.mem_data;
            r_skid_v    <= 1'b1;
        end
    end

    assign bus.cmd_busy  = (r_state != S_IDLE);
    assign bus.cmd_done  = (r_state == S_DONE);
    assign bus.cmd_err   = r_err;
    assign bus.ex_start  = (r_state == S_REQ);
    assign bus.mem_rd    = w_rd;
    assign bus.mem_adr   = r_rd_ctr[ADRWIDTH-1:0];
    assign bus.m_valid   = r_out_v;
    assign bus.m_data    = r_out_data;
    assign bus.m_last    = w_last;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_axis_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_sender
// Bench for axis_frame_sender with NUMOFDATA=8 and START_TIMEOUT=4.
// One process drives and observes the DUT at every falling edge:
//   - memory model: a read seen before a rising edge returns its data on the
//     next falling edge
//   - start responder: raises ex_startAck ack_delay cycles after ex_start goes
//     high, and drops it once ex_start falls
//   - beat recorder: stores the word and last flag of every beat
// The expected frame is simply mem[0..N-1] in order, with last on word N-1.
// ---------------------------------------------------------------------------
module tb_axis_frame_sender;
    localparam int N  = 8;
    localparam int DW = 32;

    logic clk;
    logic rst;

    axis_frame_sender_if #(.DATAWIDTH(DW), .ADRWIDTH(3)) bus ();

    axis_frame_sender #(
        .DATAWIDTH    (DW),
        .NUMOFDATA    (N),
        .START_TIMEOUT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bench state
    int          errors = 0;
    int          checks = 0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    bit            last_q [$];

    bit          rst_now = 1'b1;
    bit          go_now = 1'b0;
    int          ready_pct = 100;
    bit          ack_enable = 1'b1;
    int          ack_delay = 3;
    int          ack_cnt = 0;

    bit          pend_rd = 1'b0;
    logic [2:0]  pend_adr = '0;

    int          cyc = 0;
    int          ex_start_cycles, done_cnt, done_cyc, stab_viol, rd_cnt, rd_order_err;
    int          first_beat_cyc, last_beat_cyc;
    bit          valid_seen;
    bit          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic        prev_last;

    // Driver: one clock cycle
    task automatic drive_cycle();
        @(negedge clk);
        cyc++;
        if (pend_rd) bus.mem_data = mem[pend_adr];
        pend_rd = 1'b0;

        if (bus.ex_start === 1'b1) ex_start_cycles++;
        if (bus.cmd_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.m_valid === 1'b1) valid_seen = 1'b1;
        if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data ||
                           bus.m_last !== prev_last))
            stab_viol++;

        if (rst_now || !ack_enable) begin
            ack_cnt = 0;
            bus.ex_startAck = 1'b0;
        end else if (bus.ex_start === 1'b1) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) bus.ex_startAck = 1'b1;
        end else begin
            ack_cnt = 0;
            bus.ex_startAck = 1'b0;
        end

        rst         = rst_now;
        bus.cmd_go  = go_now;
        bus.m_ready = ($urandom_range(0, 99) < ready_pct);

        if (!rst_now && bus.m_valid === 1'b1 && bus.m_ready) begin
            got_q.push_back(bus.m_data);
            last_q.push_back(bus.m_last);
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        prev_stall = !rst_now && (bus.m_valid === 1'b1) && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;

        #1;
        if (!rst_now && bus.mem_rd === 1'b1) begin
            if (bus.mem_adr !== 3'(rd_cnt) || rd_cnt >= N) rd_order_err++;
            pend_rd  = 1'b1;
            pend_adr = bus.mem_adr;
            rd_cnt++;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        last_q.delete();
        ex_start_cycles = 0;
        done_cnt        = 0;
        done_cyc        = -1;
        stab_viol       = 0;
        rd_cnt          = 0;
        rd_order_err    = 0;
        first_beat_cyc  = -1;
        last_beat_cyc   = -1;
        valid_seen      = 1'b0;
    endtask

    task automatic start_frame();
        clear_obs();
        go_now = 1'b1;
        drive_cycle();
        go_now = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) drive_cycle();
        repeat (3) drive_cycle();
    endtask

    task automatic fill_mem(input bit random_data);
        for (int i = 0; i < N; i++) mem[i] = random_data ? $urandom : DW'(i + 100);
    endtask

    // Tests
    task automatic test_reset();
        rst_now = 1'b1;
        repeat (3) drive_cycle();
        rst_now = 1'b0;
        drive_cycle();
        checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.cmd_busy); end
        checks++; if (bus.cmd_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.cmd_done); end
        checks++; if (bus.cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.cmd_err); end
        checks++; if (bus.ex_start !== 1'b0) begin errors++; $display("FAIL reset_ex_start: got %b want 0", bus.ex_start); end
        checks++; if ({bus.mem_rd, bus.mem_adr} !== 4'd0) begin errors++; $display("FAIL reset_mem: got rd=%b adr=%0d want 0", bus.mem_rd, bus.mem_adr); end
        checks++; if ({bus.m_valid, bus.m_last} !== 2'b00 || bus.m_data !== '0) begin errors++; $display("FAIL reset_stream: got v=%b l=%b d=%h want 0", bus.m_valid, bus.m_last, bus.m_data); end
        checks++; if (bus.dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
    endtask

    task automatic test_basic();
        fill_mem(1'b0);
        ready_pct = 100; ack_enable = 1'b1; ack_delay = 3;
        start_frame();
        wait_done(100);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(DW'(i + 100));
        checks++; if (got_q.size() != N) begin errors++; $display("FAIL basic_count: got %0d words want %0d", got_q.size(), N); end
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            logic [DW-1:0] w;
            w = exp_q.pop_front();
            checks++;
            if (got_q[i] !== w || last_q[i] !== (i == N - 1)) begin
                errors++; $display("FAIL basic_word[%0d]: got %h last=%0b want %h last=%0b", i, got_q[i], last_q[i], w, (i == N - 1));
            end
        end
        checks++; if (last_beat_cyc - first_beat_cyc != N - 1) begin errors++; $display("FAIL basic_b2b: got span %0d want %0d", last_beat_cyc - first_beat_cyc, N - 1); end
        checks++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin errors++; $display("FAIL basic_done: got cnt=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc, last_beat_cyc + 1); end
        checks++; if (rd_cnt != N || rd_order_err != 0) begin errors++; $display("FAIL basic_reads: got %0d reads, %0d bad want %0d, 0", rd_cnt, rd_order_err, N); end
        checks++; if (ex_start_cycles != 3) begin errors++; $display("FAIL basic_ex_start: got %0d cycles want 3", ex_start_cycles); end
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 3; f++) begin
            fill_mem(1'b1);
            ready_pct = 50; ack_enable = 1'b1; ack_delay = $urandom_range(1, 3);
            start_frame();
            wait_done(300);
            exp_q.delete();
            for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
            checks++; if (got_q.size() != N) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", f, got_q.size(), N); end
            for (int i = 0; i < got_q.size() && i < N; i++) begin
                logic [DW-1:0] w;
                w = exp_q.pop_front();
                checks++;
                if (got_q[i] !== w || last_q[i] !== (i == N - 1)) begin
                    errors++; $display("FAIL rand_word[%0d][%0d]: got %h last=%0b want %h last=%0b", f, i, got_q[i], last_q[i], w, (i == N - 1));
                end
            end
            checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_stable[%0d]: got %0d violations want 0", f, stab_viol); end
            checks++; if (rd_cnt != N || rd_order_err != 0) begin errors++; $display("FAIL rand_reads[%0d]: got %0d reads, %0d bad want %0d, 0", f, rd_cnt, rd_order_err, N); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d want 1", f, done_cnt); end
        end
    endtask

    task automatic test_timeout();
        ready_pct = 100; ack_enable = 1'b0;
        start_frame();
        repeat (12) drive_cycle();
        checks++; if (ex_start_cycles != 4) begin errors++; $display("FAIL to_ex_start: got %0d cycles want 4", ex_start_cycles); end
        checks++; if (bus.cmd_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bus.cmd_err); end
        checks++; if (bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", bus.cmd_busy); end
        checks++; if (valid_seen || rd_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL to_traffic: got valid=%0b reads=%0d done=%0d want 0,0,0", valid_seen, rd_cnt, done_cnt); end
        ack_enable = 1'b1;
    endtask

    task automatic test_err_clear();
        fill_mem(1'b1);
        ready_pct = 80; ack_enable = 1'b1; ack_delay = 2;
        start_frame();
        drive_cycle();
        checks++; if (bus.cmd_err !== 1'b0 || bus.cmd_busy !== 1'b1) begin errors++; $display("FAIL clr_accept: got err=%b busy=%b want 0,1", bus.cmd_err, bus.cmd_busy); end
        wait_done(300);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        checks++; if (got_q.size() != N) begin errors++; $display("FAIL clr_count: got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            logic [DW-1:0] w;
            w = exp_q.pop_front();
            checks++;
            if (got_q[i] !== w || last_q[i] !== (i == N - 1)) begin
                errors++; $display("FAIL clr_word[%0d]: got %h last=%0b want %h last=%0b", i, got_q[i], last_q[i], w, (i == N - 1));
            end
        end
        checks++; if (done_cnt != 1 || bus.cmd_err !== 1'b0) begin errors++; $display("FAIL clr_done: got done=%0d err=%b want 1,0", done_cnt, bus.cmd_err); end
    endtask

    task automatic test_go_ignored();
        int  ex_at_done;
        bit  pulsed;
        fill_mem(1'b1);
        ready_pct = 70; ack_enable = 1'b1; ack_delay = 1;
        pulsed = 1'b0;
        start_frame();
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            if (!pulsed && got_q.size() == 3) begin
                go_now = 1'b1;
                pulsed = 1'b1;
            end
            drive_cycle();
            go_now = 1'b0;
        end
        ex_at_done = ex_start_cycles;
        repeat (10) drive_cycle();
        checks++; if (!pulsed) begin errors++; $display("FAIL go_pulse: got no mid-stream pulse want 1"); end
        checks++; if (done_cnt != 1 || got_q.size() != N) begin errors++; $display("FAIL go_frames: got done=%0d words=%0d want 1,%0d", done_cnt, got_q.size(), N); end
        checks++; if (ex_start_cycles != ex_at_done || bus.cmd_busy !== 1'b0) begin errors++; $display("FAIL go_restart: got ex_start %0d->%0d busy=%b want no change, 0", ex_at_done, ex_start_cycles, bus.cmd_busy); end
    endtask

    task automatic test_reset_mid();
        fill_mem(1'b1);
        ready_pct = 100; ack_enable = 1'b1; ack_delay = 2;
        start_frame();
        for (int i = 0; i < 100 && got_q.size() < 4; i++) drive_cycle();
        checks++; if (got_q.size() != 4 || bus.m_valid !== 1'b1) begin errors++; $display("FAIL mid_reach: got %0d beats valid=%b want 4,1", got_q.size(), bus.m_valid); end
        rst_now = 1'b1;
        drive_cycle();
        rst_now = 1'b0;
        drive_cycle();
        checks++; if ({bus.cmd_busy, bus.cmd_done, bus.cmd_err, bus.ex_start, bus.mem_rd, bus.m_valid, bus.m_last} !== 7'd0 ||
                      bus.mem_adr !== 3'd0 || bus.m_data !== '0 || bus.dbg_state !== 3'd0) begin
            errors++; $display("FAIL mid_outputs: got busy=%b done=%b v=%b adr=%0d d=%h st=%0d want all 0", bus.cmd_busy, bus.cmd_done, bus.m_valid, bus.mem_adr, bus.m_data, bus.dbg_state);
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_nodone: got %0d want 0", done_cnt); end
        fill_mem(1'b1);
        start_frame();
        wait_done(100);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        checks++; if (got_q.size() != N) begin errors++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), N); end
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            logic [DW-1:0] w;
            w = exp_q.pop_front();
            checks++;
            if (got_q[i] !== w || last_q[i] !== (i == N - 1)) begin
                errors++; $display("FAIL mid_word[%0d]: got %h last=%0b want %h last=%0b", i, got_q[i], last_q[i], w, (i == N - 1));
            end
        end
        checks++; if (rd_cnt != N || rd_order_err != 0 || done_cnt != 1) begin errors++; $display("FAIL mid_reads: got %0d reads, %0d bad, done=%0d want %0d,0,1", rd_cnt, rd_order_err, done_cnt, N); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_go      = 1'b0;
        bus.ex_startAck = 1'b0;
        bus.mem_data    = '0;
        bus.m_ready     = 1'b0;
        clear_obs();
        test_reset();
        test_basic();
        test_random_ready();
        test_timeout();
        test_err_clear();
        test_go_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
